// File: rtl/regfile_pkg.sv
// Core package: register-file sizing shared by decode, regfile and write-back.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t addr);
        addr_onehot = NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one busy bit per architectural register, x0 never busy.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_wen,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_lock_en,
    input  logic [REG_ADDR_W-1:0] i_lock_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    // Set is applied after clear so a new lock outlives a retiring write.
    always_comb begin
        clr_mask  = '0;
        set_mask  = '0;
        if (i_rd_wen) clr_mask = addr_onehot(i_rd_addr);
        if (i_lock_en) set_mask = addr_onehot(i_lock_addr);
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A same-cycle write-back resolves the hazard, matching the data bypass.
    always_comb begin
        o_rs1_busy = 1'b0;
        o_rs2_busy = 1'b0;
        if (!rst) begin
            o_rs1_busy = busy_q[i_rs1_addr] & ~(i_rd_wen & (i_rd_addr == i_rs1_addr));
            o_rs2_busy = busy_q[i_rs2_addr] & ~(i_rd_wen & (i_rd_addr == i_rs2_addr));
        end
    end

endmodule

// File: rtl/regfile.sv
// Integer register file: 2 combinational read ports with write bypass, 1 write port,
// plus a busy scoreboard for outstanding long-latency destinations.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_wen,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_wdata,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [DATA_WIDTH-1:0] o_rs1_data,
    output logic [DATA_WIDTH-1:0] o_rs2_data,
    input  logic                  i_lock_en,
    input  logic [REG_ADDR_W-1:0] i_lock_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Entry 0 is pinned to zero so x0 costs no storage.
    always_comb begin
        regs_d = regs_q;
        if (i_rd_wen && (i_rd_addr != '0)) begin
            regs_d[i_rd_addr] = i_rd_wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        if (!rst && (i_rs1_addr != '0)) begin
            o_rs1_data = (i_rd_wen && (i_rd_addr == i_rs1_addr)) ? i_rd_wdata : regs_q[i_rs1_addr];
        end
        if (!rst && (i_rs2_addr != '0)) begin
            o_rs2_data = (i_rd_wen && (i_rd_addr == i_rs2_addr)) ? i_rd_wdata : regs_q[i_rs2_addr];
        end
    end

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_rd_wen    (i_rd_wen),
        .i_rd_addr   (i_rd_addr),
        .i_lock_en   (i_lock_en),
        .i_lock_addr (i_lock_addr),
        .i_rs1_addr  (i_rs1_addr),
        .i_rs2_addr  (i_rs2_addr),
        .o_rs1_busy  (o_rs1_busy),
        .o_rs2_busy  (o_rs2_busy)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_rd_wdata;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic        i_lock_en;
    logic [4:0]  i_lock_addr;
    logic        o_rs1_busy;
    logic        o_rs2_busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] ref_x    [32];
    bit          ref_busy [32];

    regfile #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rd_wen    (i_rd_wen),
        .i_rd_addr   (i_rd_addr),
        .i_rd_wdata  (i_rd_wdata),
        .i_rs1_addr  (i_rs1_addr),
        .i_rs2_addr  (i_rs2_addr),
        .o_rs1_data  (o_rs1_data),
        .o_rs2_data  (o_rs2_data),
        .i_lock_en   (i_lock_en),
        .i_lock_addr (i_lock_addr),
        .o_rs1_busy  (o_rs1_busy),
        .o_rs2_busy  (o_rs2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [4:0] rd, input logic [31:0] wd,
                         input logic lk, input logic [4:0] la,
                         input logic [4:0] a1, input logic [4:0] a2);
        i_rd_wen    = wen;
        i_rd_addr   = rd;
        i_rd_wdata  = wd;
        i_lock_en   = lk;
        i_lock_addr = la;
        i_rs1_addr  = a1;
        i_rs2_addr  = a2;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (i_rd_wen && i_rd_addr == a) return i_rd_wdata;
        return ref_x[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (i_rd_wen && i_rd_addr == a) return 32'h0;
        return {31'h0, ref_busy[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ref_x[i]    = 32'h0;
            ref_busy[i] = 1'b0;
        end
    endtask

    // Compare all four outputs against the model for the current inputs.
    task automatic check_ports(input string tag);
        chk({tag, ".rs1_data"}, o_rs1_data, exp_data(i_rs1_addr));
        chk({tag, ".rs2_data"}, o_rs2_data, exp_data(i_rs2_addr));
        chk({tag, ".rs1_busy"}, 32'(o_rs1_busy), exp_busy(i_rs1_addr));
        chk({tag, ".rs2_busy"}, 32'(o_rs2_busy), exp_busy(i_rs2_addr));
    endtask

    // Inputs are applied just after a rising edge; check mid-cycle, then clock and update model.
    task automatic step(input string tag);
        #3;
        check_ports(tag);
        @(posedge clk);
        if (i_rd_wen && i_rd_addr != 5'd0) begin
            ref_x[i_rd_addr]    = i_rd_wdata;
            ref_busy[i_rd_addr] = 1'b0;
        end
        if (i_lock_en && i_lock_addr != 5'd0) ref_busy[i_lock_addr] = 1'b1;
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 5'd3, 5'd3, 5'd0);
        #2;
        chk("rst.bypass_suppressed", o_rs1_data, 32'h0);
        chk("rst.busy_zero", 32'(o_rs1_busy), 32'h0);
        #10;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_ports("post_reset");

        // Write then read back next cycle
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2);
        step("wr_x5");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #3;
        chk("rd_x5", o_rs1_data, 32'hDEADBEEF);
        step("rd_x5_model");

        // x0 ignores writes and locks
        drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd1, 5'd2);
        step("wr_x0");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #3;
        chk("x0.rs1_data", o_rs1_data, 32'h0);
        chk("x0.rs2_data", o_rs2_data, 32'h0);
        chk("x0.rs1_busy", 32'(o_rs1_busy), 32'h0);
        chk("x0.rs2_busy", 32'(o_rs2_busy), 32'h0);
        step("x0_model");

        // Same-cycle bypass
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd7);
        #3;
        chk("bypass.rs2", o_rs2_data, 32'hA5A5A5A5);
        step("bypass_model");

        // Lock x9, observe busy, then retire with a write
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        step("lock_x9");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        #3;
        chk("x9.busy_set", 32'(o_rs1_busy), 32'h1);
        step("x9_busy_model");
        drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd0);
        #3;
        chk("x9.busy_clr_same_cycle", 32'(o_rs1_busy), 32'h0);
        step("x9_write");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        #3;
        chk("x9.data", o_rs1_data, 32'h55);
        chk("x9.busy_after", 32'(o_rs2_busy), 32'h0);
        step("x9_after_model");

        // Lock and write the same register in one cycle: lock wins
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 5'd1, 5'd2);
        step("lock_wr_x3");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        #3;
        chk("x3.data", o_rs1_data, 32'h1);
        chk("x3.still_busy", 32'(o_rs2_busy), 32'h1);
        step("x3_hold");
        drive(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 5'd1, 5'd1);
        step("x3_retire");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        #3;
        chk("x3.busy_cleared", 32'(o_rs1_busy), 32'h0);
        step("x3_cleared_model");

        // Asynchronous reset pulse between edges
        drive(1'b1, 5'd4, 32'h77, 1'b1, 5'd6, 5'd1, 5'd1);
        step("x4_lock_x6");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
        #1;
        chk("pre_rst.x4", o_rs1_data, 32'h77);
        chk("pre_rst.x6_busy", 32'(o_rs2_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst.x4_data", o_rs1_data, 32'h0);
        chk("rst.x6_busy", 32'(o_rs2_busy), 32'h0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("post_rst.x4_data", o_rs1_data, 32'h0);
        chk("post_rst.x6_busy", 32'(o_rs2_busy), 32'h0);
        @(posedge clk);
        #1;

        // Random traffic, addresses biased low to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd, la, a1, a2;
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            la = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), rd, $urandom, 1'($urandom_range(0, 2) == 0), la, a1, a2);
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst = 1'b1;
                model_reset();
                #1;
                chk("rand.rst.rs1_data", o_rs1_data, 32'h0);
                chk("rand.rst.rs2_busy", 32'(o_rs2_busy), 32'h0);
                rst = 1'b0;
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register data width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the asynchronous, active-high reset.
REQ-004 SHALL have port i_rd_wen, input, 1, the write-back write enable.
REQ-005 SHALL have port i_rd_addr, input, 5, the write-back destination register.
REQ-006 SHALL have port i_rd_wdata, input, DATA_WIDTH, the write-back data.
REQ-007 SHALL have port i_rs1_addr, input, 5, the read port 1 address.
REQ-008 SHALL have port i_rs2_addr, input, 5, the read port 2 address.
REQ-009 SHALL have port o_rs1_data, output, DATA_WIDTH, the read port 1 data.
REQ-010 SHALL have port o_rs2_data, output, DATA_WIDTH, the read port 2 data.
REQ-011 SHALL have port i_lock_en, input, 1, which marks a destination as pending (load or long-latency op issued).
REQ-012 SHALL have port i_lock_addr, input, 5, the register to mark pending.
REQ-013 SHALL have port o_rs1_busy, output, 1, set when rs1 has an outstanding pending write.
REQ-014 SHALL have port o_rs2_busy, output, 1, set when rs2 has an outstanding pending write.

Function
REQ-015 SHALL hold 31 writable registers x1..x31; x0 SHALL always read 0 and SHALL ignore writes and locks.
REQ-016 SHALL write i_rd_wdata into x[i_rd_addr] at the clock edge when i_rd_wen=1 and i_rd_addr!=0.
REQ-017 SHALL make reads combinational: o_rsN_data = x[i_rsN_addr], with zero added latency.
REQ-018 SHALL bypass writes to reads: when i_rd_wen=1, i_rd_addr==i_rsN_addr and the address is !=0, o_rsN_data SHALL equal i_rd_wdata in the same cycle.
REQ-019 SHALL keep busy bits busy[1..31]: a bit is set at the edge when i_lock_en=1 and i_lock_addr matches and is !=0, and cleared at the edge when i_rd_wen=1 and i_rd_addr matches.
REQ-020 SHALL give priority to set when a lock and a write hit the same register in one cycle: busy stays 1 (the write retires the older op, and the newer op is still in flight), and the data is still written.
REQ-021 SHALL drive o_rsN_busy = busy[i_rsN_addr] & ~(i_rd_wen & i_rd_addr==i_rsN_addr); the same-cycle write-back clears the hazard combinationally, consistent with REQ-018.
REQ-022 SHALL hold o_rsN_busy at 0 for address 0.
REQ-023 SHALL allow both read ports to address the same register, each returning identical data and busy.
REQ-024 SHALL have no internal FSM and no back-pressure; the pipeline uses o_rsN_busy to stall issue.

Reset
REQ-025 SHALL, while rst=1 and regardless of clk, clear all x1..x31 to 0 and all busy bits to 0.
REQ-026 SHALL, during reset, drive o_rsN_data=0 for every address and o_rsN_busy=0, with bypass suppressed.
REQ-027 SHALL treat reset asserted mid-operation as discarding all pending locks and data; the first edge after deassertion SHALL accept writes and locks normally.

Structure
REQ-028 SHALL place REG_ADDR_W=5 and NUM_REGS=32 in the shared core package, also used by decode and wb.
REQ-029 SHALL put the busy-bit logic (REQ-019..REQ-022) in one sub-module, reg_scoreboard, instantiated inside regfile.
REQ-030 SHALL hold the storage array in regfile itself; all logic other than the storage and busy flops SHALL be combinational.

Verification
REQ-031 SHALL cover write/read: write x5=0xDEADBEEF, then on the next cycle rs1=5 -> o_rs1_data=0xDEADBEEF.
REQ-032 SHALL cover x0: write x0=0x12345678 with lock_en on x0, then rs1=0, rs2=0 -> data 0 and busy 0 on both.
REQ-033 SHALL cover bypass: in one cycle wen=1, rd=7, wdata=0xA5A5A5A5, rs2=7 -> o_rs2_data=0xA5A5A5A5 combinationally.
REQ-034 SHALL cover scoreboard: lock x9 -> o_rs1_busy=1 for rs1=9 in later cycles; write x9=0x55 -> busy=0 in the write cycle and x9 reads 0x55 after.
REQ-035 SHALL cover simultaneous events: lock and write x3=0x1 in the same cycle -> x3 reads 0x1 and busy[3] stays 1 until a later write to x3.
REQ-036 SHALL cover async reset: after x4=0x77 and a lock on x6, pulse rst between edges -> x4 reads 0 and rs=6 shows busy 0 immediately.
